// File: rtl/max7219_pkg.sv
// Shared constants, state encodings and the hex to 7-segment decoder for the
// MAX7219 display sequencer.
package max7219_pkg;

  localparam logic [7:0] RegDigit0 = 8'h01;
  localparam logic [7:0] RegDecode = 8'h09;
  localparam logic [7:0] RegIntens = 8'h0A;
  localparam logic [7:0] RegScan   = 8'h0B;
  localparam logic [7:0] RegShutdn = 8'h0C;
  localparam logic [7:0] RegTest   = 8'h0F;

  typedef enum logic [1:0] {StInit, StDigits, StIdle, StIntens} main_state_e;
  typedef enum logic [1:0] {TIdle, TIssue, TAck, TDone} txn_state_e;

  // Segment order is ABCDEFG on bits 6..0; bit 7 (DP) is added by the caller.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/max7219_txn.sv
// Single register write handshake towards the max7219 SPI engine:
// issue a start pulse, wait for busy to rise, then wait for it to fall.
module max7219_txn
  import max7219_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       idle,
  output logic       done,
  output logic [7:0] drv_addr,
  output logic [7:0] drv_data,
  output logic       drv_start,
  input  logic       drv_busy
);

  txn_state_e state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TIdle;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done    = 1'b0;
    unique case (state_q)
      TIdle: begin
        // Never start while the engine is still finishing an earlier write.
        if (req && !drv_busy) begin
          state_d = TIssue;
          addr_d  = addr;
          data_d  = data;
        end
      end
      TIssue: state_d = TAck;
      TAck: begin
        if (drv_busy) state_d = TDone;
      end
      TDone: begin
        if (!drv_busy) begin
          done    = 1'b1;
          state_d = TIdle;
        end
      end
    endcase
  end

  assign idle      = (state_q == TIdle);
  assign drv_start = (state_q == TIssue);
  assign drv_addr  = addr_q;
  assign drv_data  = data_q;

endmodule

// File: rtl/max7219_display_ctrl.sv
// Sequencer driving the max7219 write engine: init sequence, 8-digit hex
// display passes and intensity updates on request.
module max7219_display_ctrl
  import max7219_pkg::*;
#(
  parameter logic [3:0] INTENSITY  = 4'h8,
  parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic [7:0]  dp,
  input  logic        update,
  input  logic [3:0]  intensity,
  input  logic        set_intensity,
  output logic        ready,
  output logic        init_done,
  output logic [7:0]  drv_addr,
  output logic [7:0]  drv_data,
  output logic        drv_start,
  input  logic        drv_busy
);

  main_state_e state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_upd_q, pend_upd_d;
  logic        pend_int_q, pend_int_d;
  logic        init_done_q, init_done_d;
  logic [31:0] val_sh_q, val_sh_d, val_snap_q, val_snap_d;
  logic [7:0]  dp_sh_q, dp_sh_d, dp_snap_q, dp_snap_d;
  logic [3:0]  int_sh_q, int_sh_d;

  logic        req, txn_idle, txn_done, accept, snap_take;
  logic [7:0]  wr_addr, wr_data;
  logic [31:0] cur_val;
  logic [7:0]  cur_dp;

  max7219_txn u_txn (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (wr_addr),
    .data      (wr_data),
    .idle      (txn_idle),
    .done      (txn_done),
    .drv_addr  (drv_addr),
    .drv_data  (drv_data),
    .drv_start (drv_start),
    .drv_busy  (drv_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      step_q      <= 3'd0;
      idx_q       <= 3'd0;
      pend_upd_q  <= 1'b0;
      pend_int_q  <= 1'b0;
      init_done_q <= 1'b0;
      val_sh_q    <= 32'h0;
      dp_sh_q     <= 8'h0;
      val_snap_q  <= 32'h0;
      dp_snap_q   <= 8'h0;
      int_sh_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      pend_upd_q  <= pend_upd_d;
      pend_int_q  <= pend_int_d;
      init_done_q <= init_done_d;
      val_sh_q    <= val_sh_d;
      dp_sh_q     <= dp_sh_d;
      val_snap_q  <= val_snap_d;
      dp_snap_q   <= dp_snap_d;
      int_sh_q    <= int_sh_d;
    end
  end

  assign req       = (state_q != StIdle);
  assign accept    = req & txn_idle & ~drv_busy;
  assign snap_take = accept & (state_q == StDigits) & (idx_q == 3'd0);

  // Digit 0 is issued in the same cycle the snapshot is taken, so it reads the shadow.
  assign cur_val = (idx_q == 3'd0) ? val_sh_q : val_snap_q;
  assign cur_dp  = (idx_q == 3'd0) ? dp_sh_q  : dp_snap_q;

  always_comb begin
    wr_addr = 8'h00;
    wr_data = 8'h00;
    unique case (state_q)
      StInit: begin
        case (step_q)
          3'd0:    begin wr_addr = RegShutdn; wr_data = 8'h00;                end
          3'd1:    begin wr_addr = RegTest;   wr_data = 8'h00;                end
          3'd2:    begin wr_addr = RegDecode; wr_data = 8'h00;                end
          3'd3:    begin wr_addr = RegIntens; wr_data = {4'h0, INTENSITY};    end
          3'd4:    begin wr_addr = RegScan;   wr_data = {5'h00, SCAN_LIMIT};  end
          default: begin wr_addr = RegShutdn; wr_data = 8'h01;                end
        endcase
      end
      StDigits: begin
        wr_addr = RegDigit0 + {5'h00, idx_q};
        wr_data = {cur_dp[idx_q], hex_to_seg(cur_val[{idx_q, 2'b00} +: 4])};
      end
      StIntens: begin
        wr_addr = RegIntens;
        wr_data = {4'h0, int_sh_q};
      end
      StIdle: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    val_sh_d    = update ? value : val_sh_q;
    dp_sh_d     = update ? dp : dp_sh_q;
    int_sh_d    = set_intensity ? intensity : int_sh_q;
    val_snap_d  = snap_take ? val_sh_q : val_snap_q;
    dp_snap_d   = snap_take ? dp_sh_q : dp_snap_q;
    // A strobe in the clearing cycle wins so the newer request is not lost.
    pend_upd_d  = update | (pend_upd_q & ~snap_take);
    pend_int_d  = set_intensity | (pend_int_q & ~(accept & (state_q == StIntens)));
    unique case (state_q)
      StInit: begin
        if (txn_done) begin
          if (step_q == 3'd5) begin
            state_d = StDigits;
            step_d  = 3'd0;
            idx_d   = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      StDigits: begin
        if (txn_done) begin
          if (idx_q == 3'd7) begin
            state_d     = StIdle;
            idx_d       = 3'd0;
            init_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StIntens: begin
        if (txn_done) state_d = StIdle;
      end
      StIdle: begin
        if (pend_int_q) begin
          state_d = StIntens;
        end else if (pend_upd_q) begin
          state_d = StDigits;
          idx_d   = 3'd0;
        end
      end
    endcase
  end

  assign ready     = (state_q == StIdle) & ~pend_upd_q & ~pend_int_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_max7219_display_ctrl.sv
// Directed bench for max7219_display_ctrl with a behavioural max7219 busy model
// and a log of every write issued.
module tb_max7219_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = 32'h0;
  logic [7:0]  dp = 8'h0;
  logic        update = 1'b0;
  logic [3:0]  intensity = 4'h0;
  logic        set_intensity = 1'b0;
  logic        ready, init_done, drv_start, drv_busy;
  logic [7:0]  drv_addr, drv_data;

  always #5 clk = ~clk;

  max7219_display_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .value         (value),
    .dp            (dp),
    .update        (update),
    .intensity     (intensity),
    .set_intensity (set_intensity),
    .ready         (ready),
    .init_done     (init_done),
    .drv_addr      (drv_addr),
    .drv_data      (drv_data),
    .drv_start     (drv_start),
    .drv_busy      (drv_busy)
  );

  // Engine model: busy high for 40 cycles starting the cycle after start; not reset by rst_n.
  int          bcnt = 0;
  int          start_viol = 0;
  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];

  assign drv_busy = (bcnt != 0);

  always @(posedge clk) begin
    if (drv_start) begin
      log_q.push_back({drv_addr, drv_data});
      if (drv_busy) start_viol <= start_viol + 1;
      bcnt <= 40;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  logic early_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input bit watch);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (watch && init_done && !ready) early_done = 1'b1;
    end while (!ready && cyc < 3000);
    if (!ready) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_log(input string tag);
    logic [15:0] got;
    check({tag, " count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < log_q.size()) ? log_q[i] : 16'hxxxx;
      check($sformatf("%s[%0d]", tag, i), {16'h0, got}, {16'h0, exp_q[i]});
    end
  endtask

  // s lists digit data for addr1 in the top byte down to addr8 in the bottom byte.
  task automatic push_pass(input logic [63:0] s);
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(i + 1), s[63 - 8 * i -: 8]});
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0C00);
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0C01);
  endtask

  task automatic pulse_update(input logic [31:0] v, input logic [7:0] d);
    @(negedge clk);
    value  = v;
    dp     = d;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int cyc = 0;
    while (log_q.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (log_q.size() < n) check("wait_log timeout", log_q.size(), n);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst drv_start", drv_start, 0);
    check("rst drv_addr", drv_addr, 0);
    check("rst drv_data", drv_data, 0);
    check("rst ready", ready, 0);
    check("rst init_done", init_done, 0);

    // 1: init sequence and initial digit pass of zeros
    rst_n = 1'b1;
    wait_ready("t1", 1'b1);
    check("t1 init_done", init_done, 1);
    check("t1 init_done early", early_done, 0);
    exp_q.delete();
    push_init();
    push_pass(64'h7E7E7E7E_7E7E7E7E);
    check_log("t1");

    // 2: DEADBEEF
    log_q.delete();
    pulse_update(32'hDEADBEEF, 8'h00);
    check("t2 ready drop", ready, 0);
    wait_ready("t2", 1'b0);
    exp_q.delete();
    push_pass(64'h474F4F1F_3D774F3D);
    check_log("t2");

    // 3: decimal point on digit 0
    log_q.delete();
    pulse_update(32'h00000001, 8'h01);
    wait_ready("t3", 1'b0);
    exp_q.delete();
    push_pass(64'hB07E7E7E_7E7E7E7E);
    check_log("t3");

    // 4: intensity and update in the same cycle
    log_q.delete();
    @(negedge clk);
    value = 32'h12345678;
    dp = 8'h00;
    intensity = 4'h3;
    update = 1'b1;
    set_intensity = 1'b1;
    @(negedge clk);
    update = 1'b0;
    set_intensity = 1'b0;
    wait_ready("t4", 1'b0);
    exp_q.delete();
    exp_q.push_back(16'h0A03);
    push_pass(64'h7F705F5B_33796D30);
    check_log("t4");

    // 5: update arriving during the third digit write triggers one more pass
    log_q.delete();
    pulse_update(32'h11111111, 8'h00);
    wait_log(3);
    pulse_update(32'h00000000, 8'h00);
    wait_ready("t5", 1'b0);
    exp_q.delete();
    push_pass(64'h30303030_30303030);
    push_pass(64'h7E7E7E7E_7E7E7E7E);
    check_log("t5");

    // 6: async reset while a digit write waits in T_DONE
    log_q.delete();
    pulse_update(32'h22222222, 8'h00);
    wait_log(3);
    repeat (10) @(negedge clk);
    check("t6 pre addr", drv_addr, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async drv_start", drv_start, 0);
    check("t6 async drv_addr", drv_addr, 0);
    check("t6 async drv_data", drv_data, 0);
    check("t6 async init_done", init_done, 0);
    check("t6 async ready", ready, 0);
    repeat (3) @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
    wait_ready("t6", 1'b0);
    exp_q.delete();
    push_init();
    push_pass(64'h7E7E7E7E_7E7E7E7E);
    check_log("t6");
    check("start while busy", start_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
